main_ctrl_fsm: RTL
==================

MAIN_CTRL_FSM -- requirements
Module: main_ctrl_fsm

Interface
REQ-001 Parameter MEM_TIMEOUT, default 15, is the number of consecutive cycles with mem_req=1 and mem_ack=0 that triggers a timeout trap.
REQ-002 clk  in  1  single clock; all state updates occur on its rising edge.
REQ-003 rstn  in  1  reset, asynchronous and active-low.
REQ-004 instr  in  32  instruction-memory read data, sampled when ir_we=1.
REQ-005 mem_ack  in  1  memory completion strobe, one cycle per request.
REQ-006 br_taken  in  1  branch-compare result from the ALU, valid in EXEC.
REQ-007 mem_req  out  1  memory request, held until mem_ack.
REQ-008 mem_we  out  1  1 = store, 0 = read.
REQ-009 ir_we  out  1  instruction-register load strobe.
REQ-010 pc_we  out  1  PC update strobe.
REQ-011 pc_src  out  2  next-PC select: 0 = PC+4, 1 = branch target, 2 = JAL target.
REQ-012 reg_we  out  1  register-file write strobe.
REQ-013 wb_sel  out  2  write-back select: 0 = ALU, 1 = memory data, 2 = PC+4.
REQ-014 ALU_INST  out  3  ALU class sent to ALU_CU: 0 = add, 1 = branch compare, 2 = R-type, 3 = I-type ALU, 4 = pass-B.
REQ-015 INST  out  4  {instr[30], instr[14:12]} sent to ALU_CU.
REQ-016 trap  out  1  sticky fault flag.
REQ-017 trap_cause  out  2  0 = none, 1 = illegal opcode, 2 = memory timeout.
REQ-018 state  out  3  current state encoding.

Function
REQ-019 States and encodings: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=7; no other encoding is reachable.
REQ-020 FETCH drives mem_req=1 and mem_we=0; on mem_ack it drives ir_we=1 in the same cycle and moves to DECODE.
REQ-021 DECODE registers the opcode and INST from instr; the recognised opcodes are 0110011 (R), 0010011 (I), 0000011 (LOAD), 0100011 (STORE), 1100011 (BRANCH), 0110111 (LUI) and 1101111 (JAL); any other opcode moves to TRAP with cause 1, and a recognised opcode moves to EXEC.
REQ-022 ALU_INST encoding by opcode: R=2, I=3, LOAD/STORE=0, BRANCH=1, LUI=4, JAL=0; ALU_INST and INST are 0 in FETCH/DECODE and are held constant from EXEC to the end of the instruction.
REQ-023 EXEC, R/I/LUI: moves to WB.
REQ-024 EXEC, LOAD/STORE: moves to MEM.
REQ-025 EXEC, BRANCH: drives pc_we=1 and pc_src=br_taken?1:0, then moves to FETCH.
REQ-026 EXEC, JAL: drives reg_we=1, wb_sel=2, pc_we=1 and pc_src=2 in one cycle, then moves to FETCH.
REQ-027 MEM drives mem_req=1 and mem_we=(STORE); on mem_ack a STORE drives pc_we=1 with pc_src=0 and moves to FETCH, and a LOAD moves to WB.
REQ-028 WB drives reg_we=1, wb_sel=(LOAD?1:0), pc_we=1 and pc_src=0, then moves to FETCH.
REQ-029 Every strobe (ir_we, pc_we, reg_we) is high for exactly one cycle per instruction; outputs not listed for a state are 0.
REQ-030 mem_ack is ignored outside FETCH/MEM.
REQ-031 Wait counter: increments each cycle with mem_req=1 and mem_ack=0, and clears on any state change.
REQ-032 Timeout: when the wait counter reaches MEM_TIMEOUT, the next state is TRAP with cause 2; mem_ack arriving in that same cycle wins and prevents the trap.
REQ-033 Latencies with zero-wait memory: BRANCH/JAL take 3 cycles, R/I/LUI take 4, STORE takes 4 and LOAD takes 5.
REQ-034 TRAP drives trap=1 and deasserts all strobes and mem_req; it exits only on reset.

Reset
REQ-035 rstn=0 immediately forces state=FETCH, the wait counter to 0 and every output to 0 (including trap, trap_cause, ALU_INST and INST), even mid-instruction.
REQ-036 After rstn rises, FETCH asserts mem_req on the first clock edge.

Verification
REQ-037 R-type add, instr=0x002081B3 with zero-wait ack: state sequence 0,1,2,4,0; in EXEC ALU_INST=2, INST=0; in WB reg_we=1, wb_sel=0, pc_we=1.
REQ-038 SUB, instr=0x402081B3: INST=4'b1000 and ALU_INST=2 from EXEC through WB.
REQ-039 LOAD with mem_ack delayed 3 cycles in MEM: mem_req stays high for 4 cycles, then WB drives wb_sel=1 and reg_we=1; total of 8 cycles.
REQ-040 BRANCH with br_taken=1: in EXEC pc_we=1 and pc_src=1, with no reg_we; with br_taken=0: pc_src=0.
REQ-041 Opcode 0x7F: TRAP is reached after DECODE with trap=1 and cause=1, and stays there with later mem_ack pulses ignored.
REQ-042 mem_ack withheld in FETCH: TRAP is reached after 15 wait cycles with cause=2; pulsing rstn low mid-MEM returns state=0 with all outputs 0.

Source files
------------

// File: rtl/main_ctrl_fsm_if.sv
// ---------------------------------------------------------------------------
// main_ctrl_fsm_if
// Handshake/bus bundle between the main control FSM and the datapath/memory.
//
// Signals (direction seen from the controller, modport master):
//   instr      in   32  instruction word (IR contents / memory read data)
//   mem_ack    in    1  memory completion strobe
//   br_taken   in    1  branch-compare result from the ALU
//   mem_req    out   1  memory request, held until mem_ack
//   mem_we     out   1  1 = store, 0 = read
//   ir_we      out   1  instruction-register load strobe
//   pc_we      out   1  PC update strobe
//   pc_src     out   2  0 = PC+4, 1 = branch target, 2 = JAL target
//   reg_we     out   1  register-file write strobe
//   wb_sel     out   2  0 = ALU, 1 = memory data, 2 = PC+4
//   ALU_INST   out   3  ALU class for ALU_CU
//   INST       out   4  {instr[30], instr[14:12]} for ALU_CU
//   trap       out   1  sticky fault flag
//   trap_cause out   2  0 = none, 1 = illegal opcode, 2 = memory timeout
//   state      out   3  current state encoding
// The slave modport is the datapath/memory side.
// ---------------------------------------------------------------------------
interface main_ctrl_fsm_if;
    logic [31:0] instr;
    logic        mem_ack;
    logic        br_taken;
    logic        mem_req;
    logic        mem_we;
    logic        ir_we;
    logic        pc_we;
    logic [1:0]  pc_src;
    logic        reg_we;
    logic [1:0]  wb_sel;
    logic [2:0]  ALU_INST;
    logic [3:0]  INST;
    logic        trap;
    logic [1:0]  trap_cause;
    logic [2:0]  state;

    modport master (
        input  instr, mem_ack, br_taken,
        output mem_req, mem_we, ir_we, pc_we, pc_src, reg_we, wb_sel,
               ALU_INST, INST, trap, trap_cause, state
    );

    modport slave (
        output instr, mem_ack, br_taken,
        input  mem_req, mem_we, ir_we, pc_we, pc_src, reg_we, wb_sel,
               ALU_INST, INST, trap, trap_cause, state
    );
endinterface

// File: rtl/main_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// main_ctrl_fsm
// Multi-cycle control unit: FETCH -> DECODE -> EXEC -> (MEM) -> (WB) -> FETCH,
// with a sticky TRAP state for illegal opcodes and memory timeouts.
//
// Ports:
//   clk   in  1  single clock, rising edge
//   rstn  in  1  asynchronous active-low reset
//   bus   main_ctrl_fsm_if.master (see interface header for signal list)
//
// Parameter:
//   MEM_TIMEOUT  consecutive cycles of mem_req=1/mem_ack=0 that cause a trap
// ---------------------------------------------------------------------------
module main_ctrl_fsm #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rstn,
    main_ctrl_fsm_if.master   bus
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        TRAP   = 3'd7
    } state_t;

    typedef enum logic [2:0] {
        K_R, K_I, K_LOAD, K_STORE, K_BRANCH, K_LUI, K_JAL, K_ILL
    } kind_t;

    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

    state_t           state_q, state_d;
    logic [1:0]       cause_q, cause_d;
    logic [CNT_W-1:0] wait_q;
    logic             run_q;
    kind_t            kind_q;
    logic [2:0]       alu_q;
    logic [3:0]       inst_q;
    logic             mem_req_c;
    logic             timeout_c;
    logic             unused_instr_bits;

    function automatic kind_t decode_kind(input logic [6:0] opcode);
        kind_t k;
        unique case (opcode)
            7'b0110011: k = K_R;
            7'b0010011: k = K_I;
            7'b0000011: k = K_LOAD;
            7'b0100011: k = K_STORE;
            7'b1100011: k = K_BRANCH;
            7'b0110111: k = K_LUI;
            7'b1101111: k = K_JAL;
            default:    k = K_ILL;
        endcase
        return k;
    endfunction

    function automatic logic [2:0] alu_class(input kind_t k);
        logic [2:0] a;
        unique case (k)
            K_R:      a = 3'd2;
            K_I:      a = 3'd3;
            K_BRANCH: a = 3'd1;
            K_LUI:    a = 3'd4;
            default:  a = 3'd0;   // LOAD/STORE/JAL use add
        endcase
        return a;
    endfunction

    assign unused_instr_bits = ^{bus.instr[31], bus.instr[29:15], bus.instr[11:7]};

    // run_q holds every output at 0 between reset release and the first edge,
    // so mem_req only appears once the FSM is actually clocking.
    assign mem_req_c = run_q && ((state_q == FETCH) || (state_q == MEM));

    // Fires on the cycle that would be the MEM_TIMEOUT-th waiting cycle; a
    // mem_ack in that cycle suppresses it.
    assign timeout_c = mem_req_c && !bus.mem_ack &&
                       (wait_q == CNT_W'(MEM_TIMEOUT - 1));

    // State register, wait counter, sticky cause
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= FETCH;
            cause_q <= 2'd0;
            wait_q  <= '0;
            run_q   <= 1'b0;
        end else begin
            run_q   <= 1'b1;
            state_q <= state_d;
            cause_q <= cause_d;
            if (state_d != state_q)
                wait_q <= '0;
            else if (mem_req_c && !bus.mem_ack)
                wait_q <= wait_q + CNT_W'(1);
        end
    end

    // Instruction class and ALU_CU fields, captured in DECODE; only visible
    // in EXEC/MEM/WB, so no reset needed.
    always_ff @(posedge clk) begin
        if (state_q == DECODE) begin
            kind_q <= decode_kind(bus.instr[6:0]);
            alu_q  <= alu_class(decode_kind(bus.instr[6:0]));
            inst_q <= {bus.instr[30], bus.instr[14:12]};
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        unique case (state_q)
            FETCH: begin
                if (mem_req_c && bus.mem_ack) begin
                    state_d = DECODE;
                end else if (timeout_c) begin
                    state_d = TRAP;
                    cause_d = 2'd2;
                end
            end
            DECODE: begin
                if (decode_kind(bus.instr[6:0]) == K_ILL) begin
                    state_d = TRAP;
                    cause_d = 2'd1;
                end else begin
                    state_d = EXEC;
                end
            end
            EXEC: begin
                unique case (kind_q)
                    K_R, K_I, K_LUI:  state_d = WB;
                    K_LOAD, K_STORE:  state_d = MEM;
                    default:          state_d = FETCH;
                endcase
            end
            MEM: begin
                if (bus.mem_ack) begin
                    state_d = (kind_q == K_STORE) ? FETCH : WB;
                end else if (timeout_c) begin
                    state_d = TRAP;
                    cause_d = 2'd2;
                end
            end
            WB:      state_d = FETCH;
            TRAP:    state_d = TRAP;
            default: state_d = FETCH;
        endcase
    end

    // Output logic
    always_comb begin
        bus.mem_req    = mem_req_c;
        bus.mem_we     = 1'b0;
        bus.ir_we      = 1'b0;
        bus.pc_we      = 1'b0;
        bus.pc_src     = 2'd0;
        bus.reg_we     = 1'b0;
        bus.wb_sel     = 2'd0;
        bus.ALU_INST   = 3'd0;
        bus.INST       = 4'd0;
        bus.trap       = 1'b0;
        bus.trap_cause = cause_q;
        bus.state      = state_q;
        if (run_q) begin
            unique case (state_q)
                FETCH: bus.ir_we = bus.mem_ack;
                EXEC: begin
                    bus.ALU_INST = alu_q;
                    bus.INST     = inst_q;
                    if (kind_q == K_BRANCH) begin
                        bus.pc_we  = 1'b1;
                        bus.pc_src = bus.br_taken ? 2'd1 : 2'd0;
                    end else if (kind_q == K_JAL) begin
                        bus.reg_we = 1'b1;
                        bus.wb_sel = 2'd2;
                        bus.pc_we  = 1'b1;
                        bus.pc_src = 2'd2;
                    end
                end
                MEM: begin
                    bus.ALU_INST = alu_q;
                    bus.INST     = inst_q;
                    bus.mem_we   = (kind_q == K_STORE);
                    bus.pc_we    = bus.mem_ack && (kind_q == K_STORE);
                end
                WB: begin
                    bus.ALU_INST = alu_q;
                    bus.INST     = inst_q;
                    bus.reg_we   = 1'b1;
                    bus.wb_sel   = (kind_q == K_LOAD) ? 2'd1 : 2'd0;
                    bus.pc_we    = 1'b1;
                end
                TRAP:    bus.trap = 1'b1;
                default: ;
            endcase
        end
    end

endmodule
